tx_lane_sched: RTL
==================

TX_LANE_SCHED -- requirements
Module: tx_lane_sched

Interface
REQ-001 Parameter SYNC_COUNT, default 4: number of BC comma bytes emitted per sync sequence (range 1..15).
REQ-002 Parameter BC, default 8'hBC: comma/sync symbol.
REQ-003 Parameter IDLE, default 8'h7C: idle filler symbol.
REQ-004 Port clk_4f  input  1: single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1: asynchronous, active-high reset.
REQ-006 Port resync  input  1: request to re-run the sync sequence; sampled on clk_4f.
REQ-007 Port valid_0  input  1: lane 0 has a byte to send.
REQ-008 Port data_0  input  8: lane 0 byte.
REQ-009 Port ready_0  output  1: lane 0 byte is taken at this edge.
REQ-010 Port valid_1  input  1: lane 1 has a byte to send.
REQ-011 Port data_1  input  8: lane 1 byte.
REQ-012 Port ready_1  output  1: lane 1 byte is taken at this edge.
REQ-013 Port data_out  output  8: registered byte to the parallel-to-serial stage.
REQ-014 Port valid_out  output  1: registered; data_out carries lane data.
REQ-015 Port active  output  1: registered; link synced, scheduler in RUN.

Function
REQ-016 FSM states: SYNC and RUN; 4-bit sync counter cnt; 1-bit round-robin pointer ptr.
REQ-017 SYNC, each edge: data_out<=BC, valid_out<=0, cnt<=cnt+1.
REQ-018 SYNC, edge with cnt==SYNC_COUNT-1 and resync=0: state<=RUN, active<=1, cnt<=0.
REQ-019 SYNC with resync=1 at an edge: cnt<=0; state stays SYNC.
REQ-020 ready_0/ready_1 are combinational and 0 whenever state!=RUN or resync=1.
REQ-021 RUN, resync=0, exactly one valid_i=1: ready_i=1, the other ready=0.
REQ-022 RUN, resync=0, both valid=1: ready_ptr=1, the other ready=0.
REQ-023 RUN, no valid: both ready=0.
REQ-024 Transfer = valid_i && ready_i at an edge; at most one lane per edge.
REQ-025 Transfer: data_out<=data_i, valid_out<=1, ptr<=~i (granted lane gets lowest priority next).
REQ-026 RUN edge with no transfer: data_out<=IDLE, valid_out<=0, ptr unchanged.
REQ-027 Latency: a byte accepted at edge N appears on data_out/valid_out after edge N, held for exactly one cycle.
REQ-028 RUN edge with resync=1: state<=SYNC, cnt<=0, active<=0, data_out<=BC, valid_out<=0, no transfer, ptr unchanged.
REQ-029 resync held high: scheduler stays in SYNC emitting BC; sequence restarts at cnt=0 on release.
REQ-030 valid_i dropped without ready: no byte consumed; no state change beyond REQ-026.

Reset
REQ-031 reset=1 forces immediately, clock-independent: state=SYNC, cnt=0, ptr=0, data_out=8'h00, valid_out=0, active=0.
REQ-032 ready_0=ready_1=0 throughout reset.
REQ-033 Reset mid-transfer or mid-sync discards all progress; after release the full SYNC_COUNT BC sequence runs again.

Verification
REQ-034 Reset release, no valids -> edges 1-4: data_out=BC, valid_out=0; active=1 after edge 4; edges 5+: data_out=7C, valid_out=0.
REQ-035 RUN, valid_0=1 data_0=8'hA5 for one cycle -> ready_0=1 that cycle; next cycle data_out=A5, valid_out=1; following cycle 7C/0.
REQ-036 RUN, both lanes valid continuously (lane 0 bytes 01,02,03; lane 1 bytes 11,12,13), ptr=0 -> data_out sequence 01,11,02,12,03,13, valid_out=1 throughout.
REQ-037 RUN, lane 1 streams with valid_0=1 raised mid-stream -> lane 0 granted no later than the 2nd edge after raise; no byte duplicated or lost (scoreboard).
REQ-038 RUN, resync pulse 1 cycle while both lanes valid -> no ready that cycle; active=0; 4 BC bytes; active=1; arbitration resumes with preserved ptr.
REQ-039 reset asserted mid-SYNC and mid-RUN between clock edges -> outputs reach reset values before the next edge; full BC sequence repeats after release.

Source files
------------

// File: rtl/tx_lane_sched.sv
// Two-lane byte scheduler for a serial TX link: emits a BC comma sync burst,
// then round-robin arbitrates lane 0/1 bytes onto a registered output, IDLE when empty.
module tx_lane_sched #(
  parameter int unsigned SYNC_COUNT = 4,
  parameter logic [7:0]  BC         = 8'hBC,
  parameter logic [7:0]  IDLE       = 8'h7C
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       resync,
  input  logic       valid_0,
  input  logic [7:0] data_0,
  output logic       ready_0,
  input  logic       valid_1,
  input  logic [7:0] data_1,
  output logic       ready_1,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic {SYNC, RUN} state_t;

  localparam logic [3:0] LAST = 4'(SYNC_COUNT - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       ptr, ptr_nx;
  logic [7:0] data_nx;
  logic       valid_nx;
  logic       active_nx;

  // Grants only in RUN and never while resync is pending; ptr breaks ties.
  always_comb begin
    ready_0 = 1'b0;
    ready_1 = 1'b0;
    if (state == RUN && !resync) begin
      if (valid_0 && valid_1) begin
        ready_0 = ~ptr;
        ready_1 = ptr;
      end else begin
        ready_0 = valid_0;
        ready_1 = valid_1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    ptr_nx    = ptr;
    data_nx   = BC;
    valid_nx  = 1'b0;
    active_nx = active;
    case (state)
      SYNC: begin
        cnt_nx = cnt + 4'd1;
        if (resync) begin
          cnt_nx = '0;
        end else if (cnt == LAST) begin
          state_nx  = RUN;
          active_nx = 1'b1;
          cnt_nx    = '0;
        end
      end
      RUN: begin
        if (resync) begin
          state_nx  = SYNC;
          cnt_nx    = '0;
          active_nx = 1'b0;
        end else if (valid_0 && ready_0) begin
          data_nx  = data_0;
          valid_nx = 1'b1;
          ptr_nx   = 1'b1;
        end else if (valid_1 && ready_1) begin
          data_nx  = data_1;
          valid_nx = 1'b1;
          ptr_nx   = 1'b0;
        end else begin
          data_nx = IDLE;
        end
      end
      default: state_nx = SYNC;
    endcase
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state     <= SYNC;
      cnt       <= '0;
      ptr       <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      ptr       <= ptr_nx;
      data_out  <= data_nx;
      valid_out <= valid_nx;
      active    <= active_nx;
    end
  end

endmodule
